// File: rtl/hub75_pkg.sv
// Shared constants, colour type and scan FSM encoding for the HUB75 scan controller.
package hub75_pkg;

  localparam int PANEL_W   = 64;
  localparam int SCAN_ROWS = 32;
  localparam int COLOR_W   = 3;

  // Bit positions inside a colour word {R,G,B}.
  localparam int CLR_R = 2;
  localparam int CLR_G = 1;
  localparam int CLR_B = 0;

  // One bank holds SCAN_ROWS x PANEL_W pixels: {row[4:0], col[5:0]}.
  localparam int FB_ADDR_W = 11;

  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic [2:0] {
    SHIFT,
    BLANK,
    LATCH,
    ADDR,
    ON
  } scan_state_t;

endpackage

// File: rtl/frame_bank.sv
// Simple dual-port framebuffer bank: one write port, one registered read port (read-first).
module frame_bank
  import hub75_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  color_t            wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output color_t            rd_data
);

  color_t mem [2**ADDR_W];

  // NOTE: no reset on the array or read register so this maps onto block RAM;
  // the non-blocking read samples the old word when it collides with a write.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 1/32-scan driver: pixel write port into a split framebuffer, continuous row scan-out.
module hub75_scan_ctrl #(
  parameter int WIDTH     = hub75_pkg::PANEL_W,
  parameter int SCAN_ROWS = hub75_pkg::SCAN_ROWS,
  parameter int EXTRA_ON  = 0
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       write_en,
  input  logic [5:0] write_x,
  input  logic [5:0] write_y,
  input  logic [2:0] write_color,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       R1,
  output logic       G1,
  output logic       B1,
  output logic       R2,
  output logic       G2,
  output logic       B2,
  output logic       CLK,
  output logic       LAT,
  output logic       OE,
  output logic       frame_done
);
  import hub75_pkg::*;

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(SCAN_ROWS);
  localparam int ON_W  = (EXTRA_ON > 1) ? $clog2(EXTRA_ON) : 1;

  scan_state_t      state_q, state_d;
  logic [COL_W-1:0] col_q;
  logic [1:0]       slot_q;
  logic [ROW_W-1:0] row_q;
  logic [ON_W-1:0]  on_cnt_q;
  logic             primed_q;
  logic [4:0]       addr_q;
  color_t           top_q, bot_q;
  color_t           top_rd, bot_rd;

  logic                 col_last, on_last, rd_en;
  logic [FB_ADDR_W-1:0] wr_addr, rd_addr;

  assign col_last = (col_q == COL_W'(WIDTH - 1));
  assign on_last  = (on_cnt_q == ON_W'(EXTRA_ON - 1));
  assign rd_en    = (state_q == SHIFT) && (slot_q == 2'd0);
  assign wr_addr  = {write_y[4:0], write_x};
  assign rd_addr  = {5'(row_q), 6'(col_q)};

  frame_bank u_top_bank (
    .clk     (clk_in),
    .wr_en   (write_en & ~write_y[5]),
    .wr_addr (wr_addr),
    .wr_data (write_color),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (top_rd)
  );

  frame_bank u_bot_bank (
    .clk     (clk_in),
    .wr_en   (write_en & write_y[5]),
    .wr_addr (wr_addr),
    .wr_data (write_color),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (bot_rd)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d    = state_q;
    CLK        = 1'b0;
    LAT        = 1'b0;
    OE         = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      SHIFT: begin
        // The previously latched row stays lit while the next one shifts in.
        CLK = (slot_q == 2'd3);
        OE  = ~primed_q;
        if (slot_q == 2'd3 && col_last) state_d = BLANK;
      end
      BLANK: state_d = LATCH;
      LATCH: begin
        LAT        = 1'b1;
        frame_done = (row_q == ROW_W'(SCAN_ROWS - 1));
        state_d    = ADDR;
      end
      ADDR:    state_d = (EXTRA_ON > 0) ? ON : SHIFT;
      ON: begin
        OE = 1'b0;
        if (on_last) state_d = SHIFT;
      end
      default: state_d = SHIFT;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SHIFT;
      col_q    <= '0;
      slot_q   <= '0;
      row_q    <= '0;
      on_cnt_q <= '0;
      primed_q <= 1'b0;
      addr_q   <= '0;
      top_q    <= '0;
      bot_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SHIFT) begin
        slot_q <= slot_q + 2'd1;
        if (slot_q == 2'd3) col_q <= col_last ? '0 : col_q + COL_W'(1);
        // RAM data issued in slot 0 is valid in slot 1 and shown from slot 2.
        if (slot_q == 2'd1) begin
          top_q <= top_rd;
          bot_q <= bot_rd;
        end
      end
      if (state_q == LATCH) primed_q <= 1'b1;
      if (state_q == ADDR) begin
        addr_q <= 5'(row_q);
        row_q  <= (row_q == ROW_W'(SCAN_ROWS - 1)) ? '0 : row_q + ROW_W'(1);
      end
      if (state_q == ON) on_cnt_q <= (state_d == ON) ? on_cnt_q + ON_W'(1) : '0;
    end
  end

  assign {E, D, C, B, A} = addr_q;
  assign R1 = top_q[CLR_R];
  assign G1 = top_q[CLR_G];
  assign B1 = top_q[CLR_B];
  assign R2 = bot_q[CLR_R];
  assign G2 = bot_q[CLR_G];
  assign B2 = bot_q[CLR_B];

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: default and EXTRA_ON=10 instances against a cycle-position model.
module tb_hub75_scan_ctrl;

  localparam int W    = 64;
  localparam int ROWS = 32;
  localparam int P0   = 4 * W + 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       write_en = 1'b0;
  logic [5:0] write_x = '0;
  logic [5:0] write_y = '0;
  logic [2:0] write_color = '0;

  logic [4:0] addr0, addr1;
  logic [5:0] rgb0, rgb1;
  logic       clk0, lat0, oe0, fd0;
  logic       clk1, lat1, oe1, fd1;

  always #5 clk = ~clk;

  hub75_scan_ctrl #(.WIDTH(W), .SCAN_ROWS(ROWS), .EXTRA_ON(0)) dut0 (
    .clk_in(clk), .reset_n(reset_n), .write_en(write_en), .write_x(write_x),
    .write_y(write_y), .write_color(write_color),
    .A(addr0[0]), .B(addr0[1]), .C(addr0[2]), .D(addr0[3]), .E(addr0[4]),
    .R1(rgb0[5]), .G1(rgb0[4]), .B1(rgb0[3]), .R2(rgb0[2]), .G2(rgb0[1]), .B2(rgb0[0]),
    .CLK(clk0), .LAT(lat0), .OE(oe0), .frame_done(fd0)
  );

  hub75_scan_ctrl #(.WIDTH(W), .SCAN_ROWS(ROWS), .EXTRA_ON(10)) dut10 (
    .clk_in(clk), .reset_n(reset_n), .write_en(write_en), .write_x(write_x),
    .write_y(write_y), .write_color(write_color),
    .A(addr1[0]), .B(addr1[1]), .C(addr1[2]), .D(addr1[3]), .E(addr1[4]),
    .R1(rgb1[5]), .G1(rgb1[4]), .B1(rgb1[3]), .R2(rgb1[2]), .G2(rgb1[1]), .B2(rgb1[0]),
    .CLK(clk1), .LAT(lat1), .OE(oe1), .frame_done(fd1)
  );

  typedef struct packed {
    logic [4:0] addr;
    logic [5:0] rgb;
    logic       clk;
    logic       lat;
    logic       oe;
    logic       fd;
  } obs_t;

  typedef struct {
    int         x;
    int         row;
    logic [2:0] top;
    logic [2:0] bot;
    logic [5:0] exp_rgb;
  } pix_vec_t;

  pix_vec_t   vecs [6];
  logic [2:0] fb [64][64];
  logic [5:0] m_disp [2];
  logic [5:0] m_pend [2];
  int         m_e [2];
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic obs_t get_obs(input int d);
    if (d == 0) return '{addr: addr0, rgb: rgb0, clk: clk0, lat: lat0, oe: oe0, fd: fd0};
    return '{addr: addr1, rgb: rgb1, clk: clk1, lat: lat1, oe: oe1, fd: fd1};
  endfunction

  // Expected outputs for cycle k after reset release, from the row-period arithmetic.
  task automatic model_cycle(input int d, input int k, output obs_t o);
    int plen, row, p, srow, col, s;
    plen = 4 * W + 3 + m_e[d];
    row  = k / plen;
    p    = k % plen;
    srow = row % ROWS;
    col  = 0;
    s    = 0;
    o    = '0;
    o.oe = 1'b1;
    if (p < 4 * W) begin
      col = p / 4;
      s   = p % 4;
      if (s == 2) m_disp[d] = m_pend[d];
      o.clk = (s == 3);
      o.oe  = (row == 0);
    end else if (p == 4 * W + 1) begin
      o.lat = 1'b1;
      o.fd  = (srow == ROWS - 1);
    end else if (p > 4 * W + 2) begin
      o.oe = 1'b0;
    end
    if (p > 4 * W + 2) o.addr = 5'(srow);
    else               o.addr = (row == 0) ? 5'd0 : 5'((row - 1) % ROWS);
    o.rgb = m_disp[d];
    if (p < 4 * W && s == 0) m_pend[d] = {fb[col][srow], fb[col][srow + ROWS]};
  endtask

  task automatic do_write(input int x, input int y, input logic [2:0] c);
    write_en    = 1'b1;
    write_x     = 6'(x);
    write_y     = 6'(y);
    write_color = c;
    fb[x][y]    = c;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic model_reset();
    m_disp[0] = '0; m_disp[1] = '0;
    m_pend[0] = '0; m_pend[1] = '0;
  endtask

  // Called just after a negedge with reset released: compares cycles 0..n-1.
  task automatic run_scan(input int n, input int wr_from, input bit stats);
    obs_t exp_o;
    int   lat_last, lat1_last, fd_last, clk_cnt, nfd, row, col;
    lat_last = -1; lat1_last = -1; fd_last = -1; clk_cnt = 0; nfd = 0;
    for (int k = 0; k < n; k++) begin
      if (failures > 30) break;
      for (int d = 0; d < 2; d++) begin
        model_cycle(d, k, exp_o);
        check($sformatf("scan_e%0d_k%0d", m_e[d], k), 32'(get_obs(d)), 32'(exp_o));
      end
      if (stats) begin
        if (clk0) clk_cnt++;
        if (lat0) begin
          if (lat_last < 0) check("first_lat_cycle", 32'(k), 32'(257));
          check($sformatf("clk_rises_per_row_k%0d", k), 32'(clk_cnt), 32'(W));
          clk_cnt  = 0;
          lat_last = k;
        end
        if (fd0) begin
          if (fd_last < 0) check("first_frame_done", 32'(k), 32'((ROWS - 1) * P0 + 257));
          else             check("frame_done_period", 32'(k - fd_last), 32'(ROWS * P0));
          fd_last = k;
          nfd++;
        end
        if (lat1) begin
          if (lat1_last >= 0) check("row_period_extra_on", 32'(k - lat1_last), 32'(269));
          lat1_last = k;
        end
        if (k < ROWS * P0 && clk0) begin
          row = k / P0;
          col = (k % P0) / 4;
          foreach (vecs[i])
            if (vecs[i].x == col && vecs[i].row == row)
              check($sformatf("pixel_x%0d_row%0d", col, row), 32'(rgb0), 32'(vecs[i].exp_rgb));
        end
      end
      if (k >= wr_from && $urandom_range(3) == 0) begin
        write_en    = 1'b1;
        write_x     = 6'($urandom_range(63));
        write_y     = 6'($urandom_range(63));
        write_color = 3'($urandom_range(7));
        fb[write_x][write_y] = write_color;
      end else begin
        write_en = 1'b0;
      end
      @(negedge clk);
    end
    write_en = 1'b0;
    if (stats) check("frame_done_count", 32'(nfd), 32'(2));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t rst_o;
    rst_o = '{addr: 5'd0, rgb: 6'd0, clk: 1'b0, lat: 1'b0, oe: 1'b1, fd: 1'b0};
    m_e[0] = 0;
    m_e[1] = 10;
    vecs[0] = '{x: 0,  row: 0,  top: 3'b100, bot: 3'b000, exp_rgb: 6'b100_000};
    vecs[1] = '{x: 5,  row: 8,  top: 3'b000, bot: 3'b010, exp_rgb: 6'b000_010};
    vecs[2] = '{x: 63, row: 31, top: 3'b111, bot: 3'b101, exp_rgb: 6'b111_101};
    vecs[3] = '{x: 63, row: 0,  top: 3'b001, bot: 3'b110, exp_rgb: 6'b001_110};
    vecs[4] = '{x: 0,  row: 31, top: 3'b010, bot: 3'b011, exp_rgb: 6'b010_011};
    vecs[5] = '{x: 31, row: 16, top: 3'b110, bot: 3'b001, exp_rgb: 6'b110_001};

    // Framebuffer has no reset: fill every pixel while the scanner is held in reset.
    repeat (2) @(negedge clk);
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++)
        do_write(x, y, 3'($urandom_range(7)));
    foreach (vecs[i]) begin
      do_write(vecs[i].x, vecs[i].row, vecs[i].top);
      do_write(vecs[i].x, vecs[i].row + ROWS, vecs[i].bot);
    end
    check("reset_state_e0", 32'(get_obs(0)), 32'(rst_o));
    check("reset_state_e10", 32'(get_obs(1)), 32'(rst_o));

    // Two full frames plus a margin; random writes start in the second frame.
    model_reset();
    reset_n = 1'b1;
    run_scan(2 * ROWS * P0 + 300, ROWS * P0, 1'b1);

    // Restart and run into column 20 (slot 1) of row 3, then reset between edges.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    run_scan(3 * P0 + 20 * 4 + 1, 0, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_mid_shift_e0", 32'(get_obs(0)), 32'(rst_o));
    check("async_reset_mid_shift_e10", 32'(get_obs(1)), 32'(rst_o));

    // Scan restarts at row 0 col 0 and reads back the preserved framebuffer.
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    run_scan(3 * P0, 1 << 30, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
- Downstream of the pattern generator and physics renderer. Accepts single-pixel writes (write_en/write_x/write_y/write_color) into a 64x64x3 framebuffer.
- Continuously scans the framebuffer out to a 1/32-scan HUB75 panel: RGB shift, CLK, LAT, OE and row address A..E.
- Framebuffer is split into top (y<32) and bottom (y>=32) banks so R1/G1/B1 and R2/G2/B2 are fetched in the same cycle.

Parameters:
- WIDTH, 64, panel columns shifted per row.
- SCAN_ROWS, 32, row addresses; panel height = 2*SCAN_ROWS.
- EXTRA_ON, 0, additional OE-low dwell cycles per row after the address update.

Ports:
- clk_in  input  1  system clock (internal oscillator).
- reset_n  input  1  reset, asynchronous assert, active-low.
- write_en  input  1  pixel write strobe, one write per asserted cycle.
- write_x  input  6  write column.
- write_y  input  6  write row; bit 5 selects the bank (0=top, 1=bottom).
- write_color  input  3  {R,G,B}.
- A,B,C,D,E  output  1 each  displayed row address, A=LSB.
- R1,G1,B1  output  1 each  top-half pixel data.
- R2,G2,B2  output  1 each  bottom-half pixel data.
- CLK  output  1  panel shift clock.
- LAT  output  1  panel latch.
- OE  output  1  panel output enable, active-low (1 = blanked).
- frame_done  output  1  one-cycle pulse when row SCAN_ROWS-1 is latched.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: A..E=0, RGB=0, CLK=0, LAT=0, OE=1, frame_done=0.
  - State: FSM=SHIFT, col=0, shift_row=0, primed=0.
  - Framebuffer contents are not reset.
- Framebuffer:
  - Write address {write_y[4:0], write_x}; bank = write_y[5]; written on the clk_in edge where write_en=1.
  - Read address {shift_row, col} drives both banks; synchronous read, 1-cycle latency, read-first.
  - A write and a read to the same address in the same cycle returns old data. Tearing is accepted.
- FSM states: SHIFT -> BLANK -> LATCH -> ADDR -> ON (only if EXTRA_ON>0) -> SHIFT.
- SHIFT (WIDTH*4 cycles): each column uses a 4-cycle slot, s=0..3.
  - s=0: read address issued for col.
  - s=2: RGB outputs load col data. Top bank bits [2:0] -> R1,G1,B1; bottom bank -> R2,G2,B2.
  - s=3: CLK=1. CLK=0 in all other slots.
  - RGB is held from s=2 through s=1 of the next slot. Exactly WIDTH rising CLK edges per row.
  - col wraps WIDTH-1 -> 0 at the end of s=3 of the last slot; the FSM then goes to BLANK.
- BLANK (1 cycle): OE=1.
- LATCH (1 cycle): LAT=1, OE=1.
  - If shift_row==SCAN_ROWS-1, frame_done=1 this cycle.
  - Sets primed=1.
- ADDR (1 cycle): OE=1; A..E <= shift_row; shift_row increments mod SCAN_ROWS (31 -> 0).
- ON (EXTRA_ON cycles): OE=0.
- OE during SHIFT = ~primed. After the first latch, the previously latched row stays lit while the next row shifts.
- Default row period = 4*64+3 = 259 cycles; frame period = 32*259 = 8288 cycles.
- Reset mid-operation: immediate return to the reset state. A partially shifted row is discarded and OE=1 until the next latch.
- write_en is independent of the scan state and never stalls. There is no back-pressure.

Decomposition:
- Shared package hub75_pkg:
  - Constants PANEL_W=64, SCAN_ROWS=32, COLOR_W=3.
  - typedef color_t logic[2:0], with bit indices R=2, G=1, B=0.
  - FSM enum scan_state_t {SHIFT, BLANK, LATCH, ADDR, ON}.
- One sub-module, frame_bank: 2048x3 simple dual-port RAM (1 write, 1 sync read, read-first), instantiated twice.

Test Plan:
- Reset check: hold reset_n=0, then release -> A..E=0, OE=1, LAT=0, CLK=0. First LAT pulse at cycle 257 after release; OE goes low in the first SHIFT cycle after ADDR.
- Pixel mapping: write (x=0,y=0,100) and (x=5,y=40,010) before the first frame -> R1=1 at the 1st CLK rise of row 0. On the 6th CLK rise of row 8: G2=1, R1=G1=B1=0.
- Shift count: count CLK rising edges between consecutive LAT pulses -> exactly 64. LAT is always preceded by a BLANK cycle with OE=1, and OE=1 across LATCH and ADDR.
- Row/frame wrap: run 33 rows -> A..E sequence 0,1,...,31,0. frame_done pulses once, in the LATCH of row 31. frame_done period is 8288 cycles.
- EXTRA_ON=10 -> OE=0 for 10 extra cycles after each ADDR; row period is 269 cycles.
- Async reset mid-shift (during column 20 of row 3) -> outputs return to reset values in the same cycle without a clock. Scanning restarts at row 0, col 0. Framebuffer contents are preserved on readback.
